// File: rtl/bin_to_ex3_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin_ex3_pkg
// Shared types and constants for the sequential binary to Excess-3/BCD
// converter.
//   state_t        : FSM state encoding (IDLE / CONV / DONE)
//   DIGIT_W        : width of one decimal digit
//   EX3_OFFSET     : value added to a BCD digit to form its Excess-3 code
//   DABBLE_THRESH  : double-dabble correction threshold
// -----------------------------------------------------------------------------
package bin_ex3_pkg;

  localparam int         DIGIT_W       = 4;
  localparam logic [3:0] EX3_OFFSET    = 4'd3;
  localparam logic [3:0] DABBLE_THRESH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_ex3_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_ex3_seq_if
// Operand and result handshakes of the converter.
//   in_valid/in_ready   : operand handshake (bin_in, mode)
//   out_valid/out_ready : result handshake (code_out, ovf)
// Modports: master = producer/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_to_ex3_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  import bin_ex3_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [BIN_W-1:0]          bin_in;
  logic                      mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIGIT_W*DIGITS-1:0] code_out;
  logic                      ovf;

  modport master (
    output in_valid, bin_in, mode, out_ready,
    input  in_ready, out_valid, code_out, ovf
  );

  modport slave (
    input  in_valid, bin_in, mode, out_ready,
    output in_ready, out_valid, code_out, ovf
  );

endinterface

// File: rtl/bin_to_ex3_seq_dabble_digit.sv
// -----------------------------------------------------------------------------
// dabble_digit
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets +3, so the following left shift carries correctly into the next
// decimal digit.
//   i_digit : current BCD digit
//   o_digit : corrected digit, ready to be shifted
// -----------------------------------------------------------------------------
module dabble_digit
  import bin_ex3_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= DABBLE_THRESH) ? (i_digit + EX3_OFFSET) : i_digit;

endmodule

// File: rtl/bin_to_ex3_seq.sv
// -----------------------------------------------------------------------------
// bin_to_ex3_seq
// Sequential binary to Excess-3 / BCD converter. An accepted operand is
// converted by BIN_W double-dabble steps, MSB first, then the result is held
// until the consumer takes it.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of bin_to_ex3_seq_if
//          mode 0 -> Excess-3 digits, mode 1 -> plain BCD digits
//          ovf    -> operand did not fit in DIGITS decimal digits
// -----------------------------------------------------------------------------
module bin_to_ex3_seq
  import bin_ex3_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  bin_to_ex3_seq_if.slave bus
);

  localparam int              CODE_W   = DIGIT_W * DIGITS;
  localparam int              CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t              r_state;
  state_t              w_next;
  logic [BIN_W-1:0]    r_operand;
  logic [CODE_W-1:0]   r_digits;
  logic [CODE_W-1:0]   w_dabbled;
  logic [CODE_W-1:0]   w_code;
  logic                r_ovf;
  logic                r_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept;

  // Per-digit "add 3 if >= 5" correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    dabble_digit u_dabble_digit (
      .i_digit (r_digits [g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_dabbled[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_CONV;
      end
      ST_CONV: begin
        if (r_cnt == LAST_CNT) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: the {digits, operand} pair acts as one long shift register.
  // The bit leaving the top digit is a carry worth 10^DIGITS; it is dropped
  // from the digits (leaving operand mod 10^DIGITS) and recorded in ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_operand <= '0;
      r_digits  <= '0;
      r_ovf     <= 1'b0;
      r_mode    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_operand <= bus.bin_in;
            r_mode    <= bus.mode;
            r_digits  <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_CONV: begin
          r_digits  <= {w_dabbled[CODE_W-2:0], r_operand[BIN_W-1]};
          r_operand <= r_operand << 1;
          r_ovf     <= r_ovf | w_dabbled[CODE_W-1];
          r_cnt     <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output code: zero unless a finished result is being presented. The
  // Excess-3 offset is added per digit with no carry between digits.
  always_comb begin
    w_code = '0;
    if (r_state == ST_DONE) begin
      for (int d = 0; d < DIGITS; d++) begin
        w_code[d*DIGIT_W +: DIGIT_W] = r_mode ? r_digits[d*DIGIT_W +: DIGIT_W]
                                              : r_digits[d*DIGIT_W +: DIGIT_W] + EX3_OFFSET;
      end
    end
  end

  assign bus.code_out = w_code;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_bin_to_ex3_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_ex3_seq
// Scoreboard bench for bin_to_ex3_seq: one instance with default DIGITS=5 and
// one with DIGITS=4 (overflow case). Drivers push expected results computed by
// decimal arithmetic; a negedge monitor pops and compares on each handshake,
// and also checks latency, hold stability and the zero idle code.
// -----------------------------------------------------------------------------
module tb_bin_to_ex3_seq;

  localparam int BIN_W = 16;

  typedef struct packed {
    logic [39:0] code;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_ex3_seq_if #(.BIN_W(BIN_W), .DIGITS(5)) bus5 ();
  bin_to_ex3_seq_if #(.BIN_W(BIN_W), .DIGITS(4)) bus4 ();

  bin_to_ex3_seq #(.BIN_W(BIN_W), .DIGITS(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  bin_to_ex3_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  logic rnd_ready  = 1'b1;

  res_t exp5[$];
  res_t exp4[$];
  int   acc5[$];
  int   acc4[$];

  logic        prev_v   [2] = '{1'b0, 1'b0};
  logic [39:0] prev_code[2] = '{40'h0, 40'h0};
  logic        prev_ovf [2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: decimal digits of (v mod 10^digits) by division, overflow by
  // range comparison, Excess-3 as digit + 3.
  function automatic res_t model(input int digits, input logic [15:0] v, input logic m);
    res_t   r;
    longint lim = 1;
    longint rem;
    int     d;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    rem    = longint'(v) % lim;
    r.ovf  = (longint'(v) >= lim);
    r.code = '0;
    for (int k = 0; k < digits; k++) begin
      d   = int'(rem % 10);
      rem = rem / 10;
      if (!m) d = d + 3;
      r.code[k*4 +: 4] = 4'(d);
    end
    return r;
  endfunction

  task automatic send_exp(input int sel, input logic [15:0] v, input logic m, input res_t e);
    int n = 0;
    @(negedge clk);
    while (!((sel == 0) ? bus5.in_ready : bus4.in_ready)) begin
      n++;
      if (n > 500) begin
        check($sformatf("dut%0d in_ready timeout", sel), 64'(0), 64'(1));
        return;
      end
      @(negedge clk);
    end
    if (sel == 0) begin
      bus5.in_valid = 1'b1; bus5.bin_in = v; bus5.mode = m;
    end else begin
      bus4.in_valid = 1'b1; bus4.bin_in = v; bus4.mode = m;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      exp5.push_back(e); acc5.push_back(cyc);
      bus5.in_valid = 1'b0; bus5.bin_in = 16'($urandom); bus5.mode = 1'($urandom);
    end else begin
      exp4.push_back(e); acc4.push_back(cyc);
      bus4.in_valid = 1'b0; bus4.bin_in = 16'($urandom); bus4.mode = 1'($urandom);
    end
  endtask

  task automatic send(input int sel, input logic [15:0] v, input logic m);
    send_exp(sel, v, m, model((sel == 0) ? 5 : 4, v, m));
  endtask

  task automatic mon(input int sel, input logic v, input logic r,
                     input logic [39:0] code, input logic ovf);
    res_t e;
    int   a;
    if (v) begin
      if (!prev_v[sel]) begin
        if (sel == 0 ? (acc5.size() == 0) : (acc4.size() == 0)) begin
          check($sformatf("dut%0d out_valid without accept", sel), 64'(1), 64'(0));
        end else begin
          a = (sel == 0) ? acc5.pop_front() : acc4.pop_front();
          check($sformatf("dut%0d latency", sel), 64'(cyc - a), 64'(BIN_W));
        end
      end else begin
        check($sformatf("dut%0d hold code", sel), 64'(code), 64'(prev_code[sel]));
        check($sformatf("dut%0d hold ovf", sel), 64'(ovf), 64'(prev_ovf[sel]));
      end
      if (r) begin
        if (sel == 0 ? (exp5.size() == 0) : (exp4.size() == 0)) begin
          check($sformatf("dut%0d unexpected result", sel), 64'(1), 64'(0));
        end else begin
          e = (sel == 0) ? exp5.pop_front() : exp4.pop_front();
          check($sformatf("dut%0d code", sel), 64'(code), 64'(e.code));
          check($sformatf("dut%0d ovf", sel), 64'(ovf), 64'(e.ovf));
        end
      end
    end else begin
      check($sformatf("dut%0d idle code zero", sel), 64'(code), 64'(0));
    end
    prev_v[sel]    = v && !r;
    prev_code[sel] = code;
    prev_ovf[sel]  = ovf;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, bus5.out_valid, bus5.out_ready, 40'(bus5.code_out), bus5.ovf);
      mon(1, bus4.out_valid, bus4.out_ready, 40'(bus4.code_out), bus4.ovf);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) begin
      bus5.out_ready = 1'($urandom_range(0, 1));
      bus4.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp5.size() != 0 || exp4.size() != 0) begin
      n++;
      if (n > 2000) begin
        check("drain timeout", 64'(exp5.size() + exp4.size()), 64'(0));
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state();
    check("rst in_ready", 64'(bus5.in_ready), 64'(1));
    check("rst out_valid", 64'(bus5.out_valid), 64'(0));
    check("rst code_out", 64'(bus5.code_out), 64'(0));
    check("rst ovf", 64'(bus5.ovf), 64'(0));
  endtask

  initial begin
    #2_000_000;
    mismatched++;
    $display("FAIL global timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus5.in_valid = 1'b0; bus5.bin_in = '0; bus5.mode = 1'b0; bus5.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.bin_in = '0; bus4.mode = 1'b0; bus4.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    check("rst dut4 in_ready", 64'(bus4.in_ready), 64'(1));
    rst = 1'b0;

    // Directed spec values
    send_exp(0, 16'd0,     1'b0, res_t'{40'h33333, 1'b0});
    send_exp(0, 16'd65535, 1'b0, res_t'{40'h98868, 1'b0});
    send_exp(1, 16'd12345, 1'b1, res_t'{40'h2345,  1'b1});
    wait_drain();

    // Hold result with out_ready low for 5 cycles
    rnd_ready = 1'b0;
    bus5.out_ready = 1'b0;
    send_exp(0, 16'd1234, 1'b1, res_t'{40'h01234, 1'b0});
    n = 0;
    while (!bus5.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("hold out_valid seen", 64'(bus5.out_valid), 64'(1));
    repeat (5) begin
      check("hold in_ready low", 64'(bus5.in_ready), 64'(0));
      check("hold code value", 64'(bus5.code_out), 64'(20'h01234));
      @(negedge clk);
    end
    bus5.out_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b1;
    wait_drain();

    // Abort by reset in the middle of conversion
    send(0, 16'd999, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp5.delete();
    acc5.delete();
    prev_v[0] = 1'b0;
    check_reset_state();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    send_exp(0, 16'd42, 1'b0, res_t'{40'h33375, 1'b0});
    wait_drain();

    // Sweep with random issue gaps and random out_ready
    for (int v = 0; v <= 1000; v++) begin
      for (int m = 0; m < 2; m++) begin
        send(0, 16'(v), 1'(m));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // Random full-range operands on both widths
    for (int i = 0; i < 40; i++) begin
      send(1, 16'($urandom), 1'($urandom));
      send(0, 16'($urandom), 1'($urandom));
    end
    wait_drain();
    repeat (40) @(negedge clk);

    check("dut5 results all delivered", 64'(exp5.size()), 64'(0));
    check("dut4 results all delivered", 64'(exp4.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin_to_ex3_seq.md
BIN_TO_EX3_SEQ -- requirements
Module: bin_to_ex3_seq

Interface
REQ-001 Parameter BIN_W, default 16, is the binary input width (legal range 4..32).
REQ-002 Parameter DIGITS, default 5, is the number of 4-bit output digits (legal range 1..10).
REQ-003 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, is the synchronous, active-high reset.
REQ-005 Port in_valid, input, 1, means bin_in and mode are valid.
REQ-006 Port in_ready, output, 1, means the block can accept an operand.
REQ-007 Port bin_in, input, BIN_W, is the unsigned binary operand.
REQ-008 Port mode, input, 1, selects the output code: 0 = Excess-3, 1 = plain BCD.
REQ-009 Port out_valid, output, 1, means code_out and ovf hold a finished result.
REQ-010 Port out_ready, input, 1, means the consumer accepts the result.
REQ-011 Port code_out, output, 4*DIGITS, holds the result digits; the least significant digit is in bits [3:0].
REQ-012 Port ovf, output, 1, means the operand exceeds 10^DIGITS-1.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, CONV, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, in_valid&&in_ready SHALL latch bin_in and mode, clear the digit register and the ovf flag, and go to CONV.
REQ-016 CONV SHALL run exactly BIN_W cycles of double-dabble, MSB first. Each cycle:
- every digit >=5 gets +3;
- then the {digits, operand} register shifts left by 1.
REQ-017 During CONV, any 1 shifted out of the top digit SHALL set the sticky ovf flag; the kept digits are the operand modulo 10^DIGITS.
REQ-018 After the BIN_W-th CONV cycle the FSM SHALL enter DONE, so out_valid rises exactly BIN_W cycles after the accepting edge.
REQ-019 In DONE with mode=0, each code_out digit SHALL be its BCD digit +3 (values 3..12, 4-bit, no carry between digits).
REQ-020 In DONE with mode=1, code_out SHALL be the raw BCD digits.
REQ-021 code_out and ovf SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 out_valid&&out_ready SHALL return the FSM to IDLE on that edge; in_ready=1 on the next cycle, so minimum issue interval is BIN_W+2 cycles.
REQ-023 in_valid and input changes outside IDLE SHALL be ignored; the mode latched at accept governs the whole transaction.
REQ-024 code_out SHALL be all zeros while not in DONE.
REQ-025 bin_in = 0 SHALL yield all digits 0 (BCD) or all digits 3 (Excess-3) with ovf=0.

Reset
REQ-026 rst=1 at a clock edge SHALL force:
- FSM to IDLE, in_ready=1;
- out_valid=0, code_out=0, ovf=0;
- operand, digit and cycle-count registers to 0.
REQ-027 rst during CONV or DONE SHALL abort the transaction with no result produced; normal acceptance resumes the cycle after rst falls.

Structure
REQ-028 Package bin_ex3_pkg SHALL hold:
- the FSM state typedef;
- constants EX3_OFFSET=3 and DABBLE_THRESH=5;
- the digit width constant 4.
REQ-029 Sub-module dabble_digit SHALL implement the combinational per-digit "add 3 if >=5" step, instantiated DIGITS times via generate.
REQ-030 The cycle counter SHALL be $clog2(BIN_W+1) bits wide.

Verification
REQ-031 Defaults, bin_in=0, mode=0 -> code_out=20'h33333, ovf=0, out_valid 16 cycles after accept.
REQ-032 Defaults, bin_in=65535, mode=0 -> code_out=20'h98868, ovf=0.
REQ-033 Defaults, bin_in=1234, mode=1 -> code_out=20'h01234; holding out_ready=0 for 5 cycles keeps code_out stable and in_ready=0.
REQ-034 DIGITS=4, bin_in=12345, mode=1 -> code_out=16'h2345, ovf=1.
REQ-035 Assert rst for one cycle at CONV cycle 8 of bin_in=999 -> no out_valid pulse. Next operand 42, mode=0 -> code_out=20'h33375.
REQ-036 Sweep bin_in 0..1000 in both modes with random out_ready -> every result matches the reference model, and no result is lost or duplicated.
